ir_fetch_unit: RTL and testbench

Upstream neighbour of the multicycle controller in the accumulator CPU. It owns the program counter and the two-part instruction register, and it drives the memory address mux. Each instruction is assembled from two memory bytes under IRwritePart1/IRwritePart2. The unit presents upcode and operand address back to the controller and datapath.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/pc_register.sv | 39 +++
 rtl/ir_fetch_unit.sv | 107 ++++++++++
 tb/tb_ir_fetch_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: word widths, opcode map and
// the instruction-register sequencing states used by fetch unit and controller.
package cpu_pkg;

   localparam int DATA_W = 8;
   localparam int OPC_W  = 4;
   localparam int ADDR_W = 2 * DATA_W - OPC_W;

   localparam logic [OPC_W-1:0] OP_LDA = 4'h0;
   localparam logic [OPC_W-1:0] OP_STA = 4'h1;
   localparam logic [OPC_W-1:0] OP_ADD = 4'h2;
   localparam logic [OPC_W-1:0] OP_SUB = 4'h3;
   localparam logic [OPC_W-1:0] OP_JMP = 4'h4;
   localparam logic [OPC_W-1:0] OP_JZ  = 4'h5;
   localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HALF = 2'd1,
      FULL = 2'd2
   } ir_state_e;

endpackage

// File: rtl/pc_register.sv
// Program counter: loads a jump target or increments with natural wrap-around.
// A load always takes priority over an increment.
module pc_register #(
   parameter int AW       = 12,
   parameter int RESET_PC = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc_en,
   input  logic          load_en,
   input  logic [AW-1:0] load_val,
   output logic [AW-1:0] pc
);

   logic [AW-1:0] pc_q;
   logic [AW-1:0] pc_d;

   // NOTE: combinational blocks assign every output a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      pc_d = pc_q;
      if (load_en) begin
         pc_d = load_val;
      end else if (inc_en) begin
         pc_d = pc_q + AW'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= AW'(RESET_PC);
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/ir_fetch_unit.sv
// Instruction fetch unit: owns the PC and the two-byte instruction register,
// checks the Part1/Part2/jump protocol and drives the memory address mux.
module ir_fetch_unit #(
   parameter int DATA_W   = cpu_pkg::DATA_W,
   parameter int OPC_W    = cpu_pkg::OPC_W,
   parameter int RESET_PC = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [DATA_W-1:0]            memData,
   input  logic                         IRwritePart1,
   input  logic                         IRwritePart2,
   input  logic                         pcWrite,
   input  logic                         pcLoad,
   input  logic                         memAddressSel,
   output logic [2*DATA_W-OPC_W-1:0]    memAddress,
   output logic [OPC_W-1:0]             upcode,
   output logic [2*DATA_W-OPC_W-1:0]    operandAddr,
   output logic [2*DATA_W-OPC_W-1:0]    pc,
   output logic                         irValid,
   output logic                         seqError,
   output logic [15:0]                  fetchCount
);
   import cpu_pkg::*;

   localparam int AW = 2 * DATA_W - OPC_W;

   ir_state_e         state_q, state_d;
   logic [DATA_W-1:0] ir_high_q, ir_high_d;
   logic [DATA_W-1:0] ir_low_q, ir_low_d;
   logic              seq_error_q, seq_error_d;
   logic [15:0]       fetch_count_q, fetch_count_d;

   logic              ir_valid;
   logic              pc_inc_en;
   logic              pc_load_en;

   assign ir_valid   = (state_q == FULL);
   assign pc_load_en = pcLoad & ir_valid;
   assign pc_inc_en  = pcWrite & ~pcLoad;

   always_comb begin
      state_d       = state_q;
      ir_high_d     = ir_high_q;
      ir_low_d      = ir_low_q;
      seq_error_d   = seq_error_q;
      fetch_count_d = fetch_count_q;

      if (IRwritePart1 && IRwritePart2) begin
         seq_error_d = 1'b1;
      end else if (IRwritePart1) begin
         ir_high_d = memData;
         state_d   = HALF;
      end else if (IRwritePart2) begin
         if (state_q == HALF) begin
            ir_low_d = memData;
            state_d  = FULL;
            if (fetch_count_q != 16'hFFFF) begin
               fetch_count_d = fetch_count_q + 16'd1;
            end
         end else begin
            seq_error_d = 1'b1;
         end
      end

      // A jump without a complete instruction has no valid target.
      if (pcLoad && !ir_valid) begin
         seq_error_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         ir_high_q     <= '0;
         ir_low_q      <= '0;
         seq_error_q   <= 1'b0;
         fetch_count_q <= '0;
      end else begin
         state_q       <= state_d;
         ir_high_q     <= ir_high_d;
         ir_low_q      <= ir_low_d;
         seq_error_q   <= seq_error_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   pc_register #(
      .AW       (AW),
      .RESET_PC (RESET_PC)
   ) u_pc_register (
      .clk      (clk),
      .rst      (rst),
      .inc_en   (pc_inc_en),
      .load_en  (pc_load_en),
      .load_val (operandAddr),
      .pc       (pc)
   );

   assign upcode      = ir_high_q[DATA_W-1 -: OPC_W];
   assign operandAddr = {ir_high_q[DATA_W-OPC_W-1:0], ir_low_q};
   assign memAddress  = memAddressSel ? operandAddr : pc;
   assign irValid     = ir_valid;
   assign seqError    = seq_error_q;
   assign fetchCount  = fetch_count_q;

endmodule

// File: tb/tb_ir_fetch_unit.sv
// Self-checking bench for ir_fetch_unit: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a byte-level model.
module tb_ir_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  memData;
   logic        IRwritePart1, IRwritePart2, pcWrite, pcLoad, memAddressSel;
   logic [11:0] memAddress, operandAddr, pc;
   logic [3:0]  upcode;
   logic        irValid, seqError;
   logic [15:0] fetchCount;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   ir_fetch_unit dut (
      .clk           (clk),
      .rst           (rst),
      .memData       (memData),
      .IRwritePart1  (IRwritePart1),
      .IRwritePart2  (IRwritePart2),
      .pcWrite       (pcWrite),
      .pcLoad        (pcLoad),
      .memAddressSel (memAddressSel),
      .memAddress    (memAddress),
      .upcode        (upcode),
      .operandAddr   (operandAddr),
      .pc            (pc),
      .irValid       (irValid),
      .seqError      (seqError),
      .fetchCount    (fetchCount)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: two stored bytes, a "high byte seen" flag and a "complete" flag.
   int m_pc, m_hi, m_lo, m_cnt;
   bit m_half, m_valid, m_err;

   function automatic int m_opnd();
      return ((m_hi % 16) * 256) + m_lo;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pc <= 0; m_hi <= 0; m_lo <= 0; m_cnt <= 0;
         m_half <= 1'b0; m_valid <= 1'b0; m_err <= 1'b0;
      end else begin
         if (pcLoad) begin
            if (m_valid) m_pc <= m_opnd();
            else         m_err <= 1'b1;
         end else if (pcWrite) begin
            m_pc <= (m_pc + 1) % 4096;
         end
         if (IRwritePart1 && IRwritePart2) begin
            m_err <= 1'b1;
         end else if (IRwritePart1) begin
            m_hi <= int'(memData); m_half <= 1'b1; m_valid <= 1'b0;
         end else if (IRwritePart2) begin
            if (m_half) begin
               m_lo <= int'(memData); m_half <= 1'b0; m_valid <= 1'b1;
               if (m_cnt < 65535) m_cnt <= m_cnt + 1;
            end else begin
               m_err <= 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("pc", pc, m_pc);
         check("upcode", upcode, m_hi / 16);
         check("operandAddr", operandAddr, m_opnd());
         check("irValid", irValid, m_valid);
         check("seqError", seqError, m_err);
         check("fetchCount", fetchCount, m_cnt);
         check("memAddress", memAddress, memAddressSel ? m_opnd() : m_pc);
      end
   end

   task automatic drive(input logic p1, input logic p2, input logic pw, input logic pl,
                        input logic sel, input logic [7:0] d);
      @(posedge clk);
      #1;
      IRwritePart1 = p1; IRwritePart2 = p2; pcWrite = pw; pcLoad = pl;
      memAddressSel = sel; memData = d;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic pulse_rst();
      #1 rst = 1'b1;
      #1 rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      IRwritePart1 = 1'b0; IRwritePart2 = 1'b0; pcWrite = 1'b0; pcLoad = 1'b0;
      memAddressSel = 1'b0; memData = 8'h00;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      cmp_en = 1'b1;

      check("rst_pc", pc, 12'h000);
      check("rst_upcode", upcode, 4'h0);
      check("rst_operand", operandAddr, 12'h000);
      check("rst_irValid", irValid, 1'b0);
      check("rst_seqError", seqError, 1'b0);
      check("rst_fetchCount", fetchCount, 16'd0);

      // Basic fetch of 2A / BC
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h2A);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hBC);
      check("half_irValid", irValid, 1'b0);
      idle();
      check("fetch_upcode", upcode, 4'h2);
      check("fetch_operand", operandAddr, 12'hABC);
      check("fetch_irValid", irValid, 1'b1);
      check("fetch_count", fetchCount, 16'd1);

      // pcWrite + pcLoad together: load wins
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
      idle();
      check("jump_pc", pc, 12'hABC);

      // Jump to FFE, then increment across the wrap
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0F);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFE);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      check("wrap_pc0", pc, 12'hFFE);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      check("wrap_pc1", pc, 12'hFFF);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      check("wrap_pc2", pc, 12'h000);
      idle();
      check("wrap_pc3", pc, 12'h001);
      check("wrap_seqError", seqError, 1'b0);

      // Address mux follows memAddressSel with no clock edge
      memAddressSel = 1'b0; #1;
      check("mux_pc", memAddress, 12'h001);
      memAddressSel = 1'b1; #1;
      check("mux_operand", memAddress, 12'hFFE);
      memAddressSel = 1'b0;

      // Part2 straight after reset
      pulse_rst();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h99);
      idle();
      check("p2first_seqError", seqError, 1'b1);
      check("p2first_operand", operandAddr, 12'h000);
      check("p2first_irValid", irValid, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h31);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h42);
      idle();
      check("recover_operand", operandAddr, 12'h142);
      check("recover_upcode", upcode, 4'h3);
      check("recover_irValid", irValid, 1'b1);
      check("recover_seqError", seqError, 1'b1);

      // Part1 and Part2 together
      pulse_rst();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55);
      idle();
      check("both_seqError", seqError, 1'b1);
      check("both_operand", operandAddr, 12'h000);
      check("both_upcode", upcode, 4'h0);

      // Jump with no valid instruction
      pulse_rst();
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
      idle();
      check("badjump_pc", pc, 12'h002);
      check("badjump_seqError", seqError, 1'b1);

      // Reset in the middle of a fetch
      pulse_rst();
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h77);
      idle();
      check("mid_upcode_pre", upcode, 4'h7);
      #2 rst = 1'b1;
      #1;
      check("mid_pc", pc, 12'h000);
      check("mid_irValid", irValid, 1'b0);
      check("mid_upcode", upcode, 4'h0);
      rst = 1'b0;
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h12);
      idle();
      check("mid_seqError", seqError, 1'b1);
      check("mid_operand", operandAddr, 12'h000);

      // Randomized traffic, checked every cycle by the compare process
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk);
         #1;
         rst           = ($urandom_range(0, 149) == 0);
         IRwritePart1  = ($urandom_range(0, 99) < 30);
         IRwritePart2  = ($urandom_range(0, 99) < 30);
         pcWrite       = ($urandom_range(0, 99) < 35);
         pcLoad        = ($urandom_range(0, 99) < 12);
         memAddressSel = $urandom_range(0, 1) == 1;
         memData       = 8'($urandom);
      end
      rst = 1'b0;
      idle();
      idle();
      @(negedge clk);
      #1;
      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
